// File: rtl/boot_pkg.sv
// Shared bootloader definitions: receive FSM states, default timeout
// and the wire byte order used by both transmit and receive paths.
package boot_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE1,
    S_BYTE2,
    S_BYTE3,
    S_BYTE4,
    S_WRITE,
    S_DONE,
    S_ERR
  } boot_rx_state_t;

  localparam int unsigned BOOT_TIMEOUT = 50000;
  localparam bit BOOT_MSB_FIRST = 1'b1;

  // lane 0 is the first byte on the wire
  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [7:0]  b
  );
    logic [31:0] r;
    logic [1:0]  pos;
    r   = w;
    pos = BOOT_MSB_FIRST ? 2'd3 - lane : lane;
    r[{pos, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer: expired flags the TIMEOUT-th idle cycle
// since the last clear, so a byte in that same cycle still wins.
module byte_gap_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;
  logic         w_hit;

  assign w_hit     = (r_cnt == LIMIT);
  assign o_expired = i_en & w_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !w_hit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/boot_rx_loader.sv
// Bootloader receive path: length-prefixed big-endian byte stream
// from the UART reassembled into words written to instruction memory.
module boot_rx_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = BOOT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_rdy,
  output logic              o_clr_rx_rdy,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ready,
  output logic              o_word_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

  boot_rx_state_t    r_state, w_next;
  logic [15:0]       r_cnt;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;

  logic w_rx_state, w_cnt_en, w_take, w_wr_ack;
  logic w_expired, w_gap_clr;

  assign w_rx_state = r_state inside {S_LEN_HI, S_LEN_LO,
                                      S_BYTE1, S_BYTE2,
                                      S_BYTE3, S_BYTE4};
  assign w_cnt_en   = r_state inside {S_LEN_LO, S_BYTE1,
                                      S_BYTE2, S_BYTE3,
                                      S_BYTE4};
  assign w_take     = w_rx_state & i_rx_rdy;
  assign w_wr_ack   = (r_state == S_WRITE) & i_mem_ready;
  assign w_gap_clr  = i_start | w_take | ~w_cnt_en;

  assign o_clr_rx_rdy = w_take & ~i_rst;
  assign o_mem_we     = (r_state == S_WRITE);
  assign o_word_done  = w_wr_ack;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_word;
  assign o_busy       = r_state inside {S_LEN_LO, S_BYTE1,
                                        S_BYTE2, S_BYTE3,
                                        S_BYTE4, S_WRITE};
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);

  byte_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_gap_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LEN_HI: if (i_rx_rdy) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (i_rx_rdy)
          w_next = ({r_cnt[15:8], i_rx_data} == 16'd0) ?
                   S_DONE : S_BYTE1;
        else if (w_expired)
          w_next = S_ERR;
      end
      S_BYTE1: begin
        if (i_rx_rdy)       w_next = S_BYTE2;
        else if (w_expired) w_next = S_ERR;
      end
      S_BYTE2: begin
        if (i_rx_rdy)       w_next = S_BYTE3;
        else if (w_expired) w_next = S_ERR;
      end
      S_BYTE3: begin
        if (i_rx_rdy)       w_next = S_BYTE4;
        else if (w_expired) w_next = S_ERR;
      end
      S_BYTE4: begin
        if (i_rx_rdy)       w_next = S_WRITE;
        else if (w_expired) w_next = S_ERR;
      end
      S_WRITE: begin
        if (i_mem_ready)
          w_next = (r_cnt == 16'd1) ? S_DONE : S_BYTE1;
      end
      default: ;
    endcase
    if (i_start) w_next = S_LEN_HI;
  end

  // a byte taken in the same cycle as start is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_addr <= L_BASE;
    end else if (i_start) begin
      r_addr <= L_BASE;
    end else begin
      if (w_take) begin
        unique case (r_state)
          S_LEN_HI: r_cnt[15:8] <= i_rx_data;
          S_LEN_LO: r_cnt[7:0]  <= i_rx_data;
          S_BYTE1:  r_word <= put_byte(r_word, 2'd0, i_rx_data);
          S_BYTE2:  r_word <= put_byte(r_word, 2'd1, i_rx_data);
          S_BYTE3:  r_word <= put_byte(r_word, 2'd2, i_rx_data);
          S_BYTE4:  r_word <= put_byte(r_word, 2'd3, i_rx_data);
          default: ;
        endcase
      end
      if (w_wr_ack) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_boot_rx_loader.sv
// Bench for boot_rx_loader: two instances (wide address, and a 2-bit
// wrapping address) driven in lockstep against a write scoreboard.
module tb_boot_rx_loader;

  localparam int TO  = 20;
  localparam int AW0 = 14;
  localparam int BA0 = 16;
  localparam int AW1 = 2;
  localparam int BA1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rx_rdy = 1'b0;
  logic mem_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic clr0, we0, wd0, busy0, done0, err0;
  logic clr1, we1, wd1, busy1, done1, err1;
  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic [31:0] wdata0, wdata1;

  boot_rx_loader #(
    .ADDR_W(AW0), .BASE_ADDR(BA0), .TIMEOUT(TO)
  ) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_rx_data(rx_data), .i_rx_rdy(rx_rdy),
    .o_clr_rx_rdy(clr0), .o_mem_we(we0),
    .o_mem_addr(addr0), .o_mem_wdata(wdata0),
    .i_mem_ready(mem_ready), .o_word_done(wd0),
    .o_busy(busy0), .o_done(done0), .o_err(err0)
  );

  boot_rx_loader #(
    .ADDR_W(AW1), .BASE_ADDR(BA1), .TIMEOUT(TO)
  ) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_rx_data(rx_data), .i_rx_rdy(rx_rdy),
    .o_clr_rx_rdy(clr1), .o_mem_we(we1),
    .o_mem_addr(addr1), .o_mem_wdata(wdata1),
    .i_mem_ready(mem_ready), .o_word_done(wd1),
    .o_busy(busy1), .o_done(done1), .o_err(err1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall = 0;
  int wcnt = 0;
  int wlen = 0;
  int widx = 0;
  int nwr0 = 0, nwr1 = 0, nwd0 = 0, nwd1 = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // memory model: stall cycles of not-ready, then accept; plus scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (we0) begin
      mem_ready = (wcnt == stall);
      wcnt = (wcnt == stall) ? 0 : wcnt + 1;
      wlen++;
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
      wlen = 0;
    end
    #1;
    if (we0 && mem_ready) begin
      nwr0++;
      chk("we_len", 32'(wlen), 32'(stall + 1));
      chk("wd0_on_ack", 32'(wd0), 32'd1);
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr0_unexp: got addr %h want none", addr0);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", 32'(addr0), e.addr);
        chk("wr0_data", wdata0, e.data);
      end
    end
    if (we1 && mem_ready) begin
      nwr1++;
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr1_unexp: got addr %h want none", addr1);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", 32'(addr1), e.addr);
        chk("wr1_data", wdata1, e.data);
      end
    end
    if (wd0) nwd0++;
    if (wd1) nwd1++;
  end

  task automatic clear_counts();
    nwr0 = 0; nwr1 = 0; nwd0 = 0; nwd1 = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #2;
    while (!clr0 && t < 300) begin
      @(negedge clk); #2;
      t++;
    end
    if (!clr0) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_accept: got no clr want clr for %h", b);
    end
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    e.data = w;
    e.addr = 32'((BA0 + widx) % (1 << AW0));
    q0.push_back(e);
    e.addr = 32'((BA1 + widx) % (1 << AW1));
    q1.push_back(e);
    widx++;
  endtask

  task automatic send_word(input logic [31:0] w);
    push_word(w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    widx = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(done0 && done1) && t < 1000) begin
      @(negedge clk); #2;
      t++;
    end
    if (!(done0 && done1)) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: got done %b%b want 11", done0, done1);
    end
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] w0;
    int          stl;
    logic [31:0] eaddr0;
    logic [31:0] eaddr1;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'd1, 32'hDEADBEEF, 0, 32'd17, 32'd0};
    tbl[1] = '{16'd3, 32'h11223344, 5, 32'd19, 32'd2};
    tbl[2] = '{16'd0, 32'h00000000, 0, 32'd16, 32'd3};
    tbl[3] = '{16'd2, 32'hA5A5F00F, 1, 32'd18, 32'd1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_clr", 32'(clr0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_addr0", 32'(addr0), 32'(BA0));
    chk("rst_addr1", 32'(addr1), 32'(BA1));
    chk("rst_wdata", wdata0, 32'd0);

    rx_rdy = 1'b1;
    rx_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_clr", 32'(clr0), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);
    rx_rdy = 1'b0;

    for (int i = 0; i < 4; i++) begin
      stall = tbl[i].stl;
      pulse_start();
      clear_counts();
      send_byte(tbl[i].cnt[15:8]);
      send_byte(tbl[i].cnt[7:0]);
      if (tbl[i].cnt == 16'd0)
        chk("cnt0_done_lat", 32'(done0), 32'd1);
      for (int j = 0; j < int'(tbl[i].cnt); j++)
        send_word(tbl[i].w0 ^ (32'(j) * 32'h01030507));
      wait_done();
      chk("vec_done1", 32'(done1), 32'd1);
      chk("vec_err", 32'(err0), 32'd0);
      chk("vec_busy", 32'(busy0), 32'd0);
      chk("vec_nwr0", 32'(nwr0), 32'(tbl[i].cnt));
      chk("vec_nwr1", 32'(nwr1), 32'(tbl[i].cnt));
      chk("vec_nwd0", 32'(nwd0), 32'(tbl[i].cnt));
      chk("vec_nwd1", 32'(nwd1), 32'(tbl[i].cnt));
      chk("vec_addr0", 32'(addr0), tbl[i].eaddr0);
      chk("vec_addr1", 32'(addr1), tbl[i].eaddr1);
      chk("vec_q", 32'(q0.size() + q1.size()), 32'd0);
    end

    // timeout after two payload bytes
    stall = 0;
    pulse_start();
    clear_counts();
    chk("start_clr_done", 32'(done0), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("to_early_err", 32'(err0), 32'd0);
    chk("to_early_busy", 32'(busy0), 32'd1);
    @(posedge clk);
    #1;
    chk("to_err0", 32'(err0), 32'd1);
    chk("to_err1", 32'(err1), 32'd1);
    chk("to_busy", 32'(busy0), 32'd0);
    chk("to_nwr", 32'(nwr0), 32'd0);
    pulse_start();
    chk("to_clr_err", 32'(err0), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hCAFEF00D);
    wait_done();
    chk("to_recover_nwr", 32'(nwr0), 32'd1);

    // byte on the expiry cycle is still accepted
    pulse_start();
    clear_counts();
    send_byte(8'h00);
    send_byte(8'h01);
    push_word(32'h11223344);
    send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h22);
    chk("exp_edge_err", 32'(err0), 32'd0);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_done();
    chk("exp_edge_nwr", 32'(nwr1), 32'd1);

    // start mid-word discards partial word and rewinds address
    pulse_start();
    clear_counts();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h01020304);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_start();
    chk("mid_addr0", 32'(addr0), 32'(BA0));
    chk("mid_addr1", 32'(addr1), 32'(BA1));
    chk("mid_busy", 32'(busy0), 32'd0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h55667788);
    wait_done();
    chk("mid_nwr", 32'(nwr0), 32'd2);

    // reset while a write is stalled
    stall = 10;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h0BADF00D);
    @(negedge clk);
    #2;
    chk("rw_we", 32'(we0), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rw_we0", 32'(we0), 32'd0);
    chk("rw_wd", 32'(wd0), 32'd0);
    chk("rw_busy", 32'(busy0), 32'd0);
    chk("rw_done", 32'(done0), 32'd0);
    chk("rw_err", 32'(err0), 32'd0);
    chk("rw_clr", 32'(clr0), 32'd0);
    chk("rw_addr0", 32'(addr0), 32'(BA0));
    chk("rw_wdata", wdata0, 32'd0);
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
